// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score event scheduler.
//   src_t    - scoring source encoding (also the add_src output encoding)
//   state_t  - transfer FSM states
//   PEND_W   - width of each per-source pending counter
//   next_src - round-robin successor of a source (wraps wall -> enemy)
package score_pkg;

  typedef enum logic [1:0] {
    SRC_ENEMY = 2'd0,
    SRC_JEWEL = 2'd1,
    SRC_WALL  = 2'd2
  } src_t;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam int unsigned NUM_SRC       = 3;
  localparam int unsigned PEND_W        = 3;
  localparam int unsigned DEF_ENEMY_PTS = 20;
  localparam int unsigned DEF_JEWEL_PTS = 50;
  localparam int unsigned DEF_WALL_PTS  = 5;
  localparam int unsigned DEF_PEND_MAX  = 7;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    case (s)
      SRC_ENEMY: return SRC_JEWEL;
      SRC_JEWEL: return SRC_WALL;
      default:   return SRC_ENEMY;
    endcase
  endfunction

endpackage

// File: rtl/score_src_counter.sv
// score_src_counter: one scoring source.
// Rising-edge detects level_i (qualified by gate_i) and keeps a saturating count of
// events not yet transferred.
//   clk_i, reset_i - clock, synchronous active-high reset
//   clear_i        - flush: clears all state, events in this cycle are ignored
//   level_i        - raw collision level
//   gate_i         - event qualifier (wall: once per explosion; others tied high)
//   dec_i          - an accepted transfer of this source
//   event_o        - qualified event this cycle (combinational)
//   count_o        - pending events
//   drop_o         - one-cycle pulse after an event was lost at saturation
module score_src_counter #(
  parameter int unsigned PendW   = 3,
  parameter int unsigned PendMax = 7
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             level_i,
  input  logic             gate_i,
  input  logic             dec_i,
  output logic             event_o,
  output logic [PendW-1:0] count_o,
  output logic             drop_o
);

  logic             prev_q;
  logic [PendW-1:0] count_q, count_d;
  logic             drop_q, drop_d;

  assign event_o = level_i & ~prev_q & gate_i & ~clear_i;

  always_comb begin
    count_d = count_q;
    drop_d  = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (event_o && !dec_i) begin
      if (count_q == PendW'(PendMax)) begin
        drop_d = 1'b1;
      end else begin
        count_d = count_q + PendW'(1);
      end
    end else if (dec_i && !event_o) begin
      count_d = count_q - PendW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q  <= 1'b0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      prev_q  <= clear_i ? 1'b0 : level_i;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign count_o = count_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/score_event_scheduler.sv
// score_event_scheduler: serialises enemy/jewel/wall scoring events into the score
// accumulator over a valid/ready handshake, one transfer per GRANT/IDLE pair.
//   clk, reset            - clock, synchronous active-high reset
//   game_on               - scoring enabled; low flushes counters and any offer
//   collision_*           - collision levels (enemy, jewel, wall)
//   explosion             - high for the whole explosion; bounds wall scoring
//   add_ready             - accumulator accepts the current offer
//   add_valid/value/src   - current offer
//   pending               - sum of the per-source pending counters
//   drop_pulse            - an event was lost to saturation
module score_event_scheduler
  import score_pkg::*;
#(
  parameter int unsigned ENEMY_PTS = DEF_ENEMY_PTS,
  parameter int unsigned JEWEL_PTS = DEF_JEWEL_PTS,
  parameter int unsigned WALL_PTS  = DEF_WALL_PTS,
  parameter int unsigned PEND_MAX  = DEF_PEND_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_on,
  input  logic       collision_blast_enemy,
  input  logic       collision_player_jewl,
  input  logic       collision_blast_wall,
  input  logic       explosion,
  input  logic       add_ready,
  output logic       add_valid,
  output logic [7:0] add_value,
  output logic [1:0] add_src,
  output logic [4:0] pending,
  output logic       drop_pulse
);

  state_t      state_q, state_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  add_src_q, add_src_d;
  logic [7:0]  add_value_q, add_value_d;
  logic        wall_done_q, wall_done_d;

  logic [NUM_SRC-1:0] level, gate, dec, ev, drop, nz;
  logic [PEND_W-1:0]  cnt [NUM_SRC];
  logic               unused_ev;

  assign level = {collision_blast_wall, collision_player_jewl, collision_blast_enemy};
  // Only the first qualifying wall hit of an explosion scores.
  assign gate  = {explosion & ~wall_done_q, 1'b1, 1'b1};
  assign unused_ev = ^ev[1:0];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign dec[i] = (state_q == S_GRANT) & add_ready & (add_src_q == 2'(i));
    assign nz[i]  = |cnt[i];

    score_src_counter #(
      .PendW   (PEND_W),
      .PendMax (PEND_MAX)
    ) u_cnt (
      .clk_i   (clk),
      .reset_i (reset),
      .clear_i (~game_on),
      .level_i (level[i]),
      .gate_i  (gate[i]),
      .dec_i   (dec[i]),
      .event_o (ev[i]),
      .count_o (cnt[i]),
      .drop_o  (drop[i])
    );
  end

  // wall_done re-arms in any cycle the explosion is low.
  always_comb begin
    wall_done_d = wall_done_q;
    if (!game_on || !explosion) begin
      wall_done_d = 1'b0;
    end else if (ev[SRC_WALL]) begin
      wall_done_d = 1'b1;
    end
  end

  // Round-robin: search starts one past the last granted source.
  logic [1:0] cand1, cand2, cand3, win_src;
  logic       win_found;
  logic [7:0] win_pts;

  assign cand1 = next_src(last_grant_q);
  assign cand2 = next_src(cand1);
  assign cand3 = next_src(cand2);

  always_comb begin
    win_found = 1'b1;
    win_src   = cand1;
    if (nz[cand1]) begin
      win_src = cand1;
    end else if (nz[cand2]) begin
      win_src = cand2;
    end else if (nz[cand3]) begin
      win_src = cand3;
    end else begin
      win_found = 1'b0;
    end
  end

  always_comb begin
    case (win_src)
      SRC_JEWEL: win_pts = 8'(JEWEL_PTS);
      SRC_WALL:  win_pts = 8'(WALL_PTS);
      default:   win_pts = 8'(ENEMY_PTS);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    add_value_d  = add_value_q;
    add_src_d    = add_src_q;
    last_grant_d = last_grant_q;
    if (!game_on) begin
      // An in-flight offer is abandoned; its counter was cleared by the flush.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_d     = S_GRANT;
            add_value_d = win_pts;
            add_src_d   = win_src;
          end
        end
        S_GRANT: begin
          if (add_ready) begin
            state_d      = S_IDLE;
            last_grant_d = add_src_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= SRC_WALL;
      add_src_q    <= SRC_ENEMY;
      add_value_q  <= 8'd0;
      wall_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      add_src_q    <= add_src_d;
      add_value_q  <= add_value_d;
      wall_done_q  <= wall_done_d;
    end
  end

  assign add_valid  = (state_q == S_GRANT);
  assign add_value  = add_value_q;
  assign add_src    = add_src_q;
  assign pending    = 5'(cnt[0]) + 5'(cnt[1]) + 5'(cnt[2]);
  assign drop_pulse = |drop;

endmodule

// File: doc/score_event_scheduler.md
# score_event_scheduler

Sequences scoring events from the collision detectors into the score accumulator one transfer at a time, so that simultaneous or back-to-back events are never lost. Sits between the collision/explosion logic and the score accumulator. Edge-detects each collision source and limits wall scoring to once per explosion. Buffers pending events per source, arbitrates round-robin, and issues point values over a valid/ready handshake.

## Interface
Parameters:
- ENEMY_PTS, 20, points per enemy kill
- JEWEL_PTS, 50, points per jewel pickup
- WALL_PTS, 5, points per wall destroyed (max one per explosion)
- PEND_MAX, 7, saturation limit of each per-source pending counter (3-bit)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- game_on  in  1  scoring enabled; low flushes all state
- collision_blast_enemy  in  1  level, blast hits enemy
- collision_player_jewl  in  1  level, player touches jewel
- collision_blast_wall  in  1  level, blast hits wall
- explosion  in  1  high for the whole explosion
- add_ready  in  1  accumulator accepts add_value this cycle
- add_valid  out  1  add_value is valid
- add_value  out  8  points to add
- add_src  out  2  source of current transfer: 0 enemy, 1 jewel, 2 wall
- pending  out  5  sum of all three pending counters
- drop_pulse  out  1  one-cycle pulse: an event was lost to saturation

## Operation
- Edge detect: per source, prev register; event = in & ~prev. prev updates every cycle while game_on.
- Wall gating: wall event counts only if explosion=1 and wall_done=0; it then sets wall_done. wall_done clears in any cycle with explosion=0.
- Pending counters (3-bit, per source): +1 on event, -1 on accepted transfer of that source, same cycle both → unchanged. At PEND_MAX an event without a simultaneous decrement is dropped and drop_pulse=1 next cycle.
- Arbiter: round-robin over sources with nonzero pending, search starts at last_grant+1 (mod 3). last_grant resets to 2 (wall), so enemy wins first.
- FSM states:
  - IDLE: if any pending → load add_value/add_src from the winner, go GRANT.
  - GRANT: add_valid=1, add_value/add_src stable. On add_ready: decrement the granted counter, update last_grant, go IDLE.
- game_on=0: counters, prev, wall_done and drop_pulse are cleared, and the FSM is forced to IDLE next cycle. An in-flight GRANT is abandoned without decrement. Events in that cycle are ignored.
- add_value is zero-extended from the parameter and holds its last value in IDLE (don't-care while add_valid=0).

## Timing
- Reset values: add_valid=0, add_value=0, add_src=0, pending=0, drop_pulse=0, FSM=IDLE, last_grant=2, all counters/prev/wall_done=0.
- Latency: input rises in cycle n (low in n-1) → counter visible n+1 → FSM in IDLE enters GRANT, add_valid=1 in cycle n+2.
- Throughput: one transfer per 2 cycles minimum (GRANT, IDLE). add_valid holds until add_ready. add_ready while add_valid=0 is ignored.
- pending is registered and reflects counter state after each edge.
- Reset wins over game_on and all events in the same cycle.

## Structure
- Package score_pkg: enum src_t {SRC_ENEMY, SRC_JEWEL, SRC_WALL}, enum state_t {S_IDLE, S_GRANT}, default point constants, PEND_W=3.
- Sub-module score_src_counter (edge detect + saturating up/down counter + drop flag), instantiated three times. Wall gating, arbiter and FSM stay in the top.

## Test plan
- Single enemy: reset, game_on=1, enemy high 3 cycles from cycle 10, add_ready=1 → add_valid only at cycle 12 for one cycle, add_value=20, add_src=0; pending back to 0.
- Simultaneous: enemy, jewel and wall (explosion=1) rise in the same cycle, add_ready=1 → transfers 20, 50, 5 in that order, 2 cycles apart. Summed total 75.
- Wall once per explosion: explosion high 20 cycles, wall toggles 4 times → exactly one transfer of 5. Explosion low 1 cycle then high, wall toggles → second 5.
- Backpressure and saturation: add_ready=0, 9 jewel pulses → pending=7, drop_pulse twice. add_valid/add_value=50 stable throughout. Release add_ready → 7 transfers.
- Flush: 3 enemy events pending, in GRANT, drop game_on for 1 cycle → add_valid=0 and pending=0 next cycle, no transfer accepted.
- Reset mid-GRANT with add_ready=1 in the same cycle → no decrement counted, all outputs at reset values next cycle.
